axis_stream_receiver: RTL and testbench

AXIS_STREAM_RECEIVER -- requirements
Module: axis_stream_receiver

---
 rtl/axis_stream_receiver.sv | 188 ++++++++++++++++++
 tb/tb_axis_stream_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_receiver.sv
// axis_stream_receiver
// AXI4-Stream slave that buffers beats in a first-word-fall-through FIFO and
// tracks packet framing: byte count per packet (saturating) and TID stability.
//
// Ports
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   TVALID/TREADY          slave handshake; TREADY = FIFO not full (registered)
//   TDATA/TKEEP/TLAST      beat payload, byte qualifiers, end of packet
//   TUSER/TID              sideband stored with each beat
//   out_valid/out_ready    downstream handshake, FIFO head on out_* fields
//   out_data/keep/last/user/id  buffered beat fields
//   pkt_done               one-cycle pulse after a TLAST beat is accepted
//   id_err                 sticky, TID changed inside a packet
//   pkt_bytes              byte count of the last completed packet
//
// Optional build macro AXIS_RX_STATS_EN adds pkt_count[15:0] and
// beat_count[31:0] (wrapping counters of completed packets / accepted beats).

module axis_stream_receiver #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    TVALID,
  output logic                    TREADY,
  input  logic [DATA_WIDTH-1:0]   TDATA,
  input  logic [DATA_WIDTH/8-1:0] TKEEP,
  input  logic                    TLAST,
  input  logic [3:0]              TUSER,
  input  logic [1:0]              TID,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic                    out_last,
  output logic [3:0]              out_user,
  output logic [1:0]              out_id,
  output logic                    pkt_done,
  output logic                    id_err,
  output logic [15:0]             pkt_bytes
`ifdef AXIS_RX_STATS_EN
  ,
  output logic [15:0]             pkt_count,
  output logic [31:0]             beat_count
`endif
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned POP_W  = KEEP_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = DATA_WIDTH + KEEP_W + 1 + 4 + 2;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  // Number of set bits in a TKEEP vector.
  function automatic logic [POP_W-1:0] popcount(input logic [KEEP_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tready_q, out_valid_q;
  logic             push, pop;

  assign push = TVALID && tready_q;
  assign pop  = out_valid_q && out_ready;

  // Occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and registered full/empty flags.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tready_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {TDATA, TKEEP, TLAST, TUSER, TID};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      tready_q    <= (count_d != CNT_W'(FIFO_DEPTH));
      out_valid_q <= (count_d != '0);
    end
  end

  assign TREADY    = tready_q;
  assign out_valid = out_valid_q;
  assign {out_data, out_keep, out_last, out_user, out_id} = mem_q[rd_ptr_q];

  // ------------------------------------------------------- packet tracker
  state_e           state_q;
  logic [1:0]       pkt_id_q;
  logic [15:0]      acc_q;
  logic             pkt_done_q, id_err_q;
  logic [15:0]      pkt_bytes_q;
  logic [POP_W-1:0] beat_bytes;
  logic [16:0]      acc_sum;
  logic [15:0]      acc_sat;

  assign beat_bytes = popcount(TKEEP);
  assign acc_sum    = {1'b0, acc_q} + 17'(beat_bytes);
  assign acc_sat    = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      pkt_id_q    <= '0;
      acc_q       <= '0;
      pkt_done_q  <= 1'b0;
      id_err_q    <= 1'b0;
      pkt_bytes_q <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      if (push) begin
        case (state_q)
          IDLE: begin
            if (TLAST) begin
              pkt_done_q  <= 1'b1;
              pkt_bytes_q <= 16'(beat_bytes);
            end else begin
              state_q  <= IN_PKT;
              pkt_id_q <= TID;
              acc_q    <= 16'(beat_bytes);
            end
          end
          IN_PKT: begin
            if (TID != pkt_id_q) id_err_q <= 1'b1;
            if (TLAST) begin
              state_q     <= IDLE;
              pkt_done_q  <= 1'b1;
              pkt_bytes_q <= acc_sat;
            end else begin
              acc_q <= acc_sat;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pkt_done  = pkt_done_q;
  assign id_err    = id_err_q;
  assign pkt_bytes = pkt_bytes_q;

`ifdef AXIS_RX_STATS_EN
  // Free-running wrapping statistics.
  logic [15:0] pkt_count_q;
  logic [31:0] beat_count_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pkt_count_q  <= '0;
      beat_count_q <= '0;
    end else if (push) begin
      beat_count_q <= beat_count_q + 32'd1;
      if (TLAST) pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_axis_stream_receiver.sv
// Directed bench for axis_stream_receiver (DATA_WIDTH=16, FIFO_DEPTH=4).
// Outputs are sampled on the falling edge, inputs driven right after.

module tb_axis_stream_receiver;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        TVALID, TREADY;
  logic [15:0] TDATA;
  logic [1:0]  TKEEP;
  logic        TLAST;
  logic [3:0]  TUSER;
  logic [1:0]  TID;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic        out_last;
  logic [3:0]  out_user;
  logic [1:0]  out_id;
  logic        pkt_done, id_err;
  logic [15:0] pkt_bytes;
`ifdef AXIS_RX_STATS_EN
  logic [15:0] pkt_count;
  logic [31:0] beat_count;
`endif

  always #5 ACLK = ~ACLK;

  axis_stream_receiver #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP),
    .TLAST(TLAST), .TUSER(TUSER), .TID(TID),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .out_user(out_user), .out_id(out_id),
    .pkt_done(pkt_done), .id_err(id_err), .pkt_bytes(pkt_bytes)
`ifdef AXIS_RX_STATS_EN
    , .pkt_count(pkt_count), .beat_count(beat_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] k,
                       input logic l, input logic [1:0] id, input logic ord);
    TVALID = v; TDATA = d; TKEEP = k; TLAST = l; TUSER = d[3:0]; TID = id;
    out_ready = ord;
  endtask

  // One row per cycle: outputs expected before this cycle's edge, then inputs.
  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
    logic [1:0]  id;
    logic        ord;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_done;
    logic [15:0] e_bytes;
    logic        e_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // single beat; 3-beat TID=2 packet (2+2+1); TID 1->3 packet (2+1+0)
    tbl[0]  = '{1'b1, 16'hA5A5, 2'b11, 1'b1, 2'd0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b1,  1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b1, 16'd2, 1'b0};
    tbl[2]  = '{1'b1, 16'h1111, 2'b11, 1'b0, 2'd2, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd2, 1'b0};
    tbl[3]  = '{1'b1, 16'h2222, 2'b11, 1'b0, 2'd2, 1'b1,  1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'd2, 1'b0};
    tbl[4]  = '{1'b1, 16'h3333, 2'b01, 1'b1, 2'd2, 1'b1,  1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 16'd2, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b1,  1'b1, 1'b1, 16'h3333, 1'b1, 1'b1, 16'd5, 1'b0};
    tbl[6]  = '{1'b1, 16'h4444, 2'b11, 1'b0, 2'd1, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd5, 1'b0};
    tbl[7]  = '{1'b1, 16'h5555, 2'b10, 1'b0, 2'd3, 1'b1,  1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 16'd5, 1'b0};
    tbl[8]  = '{1'b1, 16'h6666, 2'b00, 1'b1, 2'd1, 1'b1,  1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'd5, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b1,  1'b1, 1'b1, 16'h6666, 1'b1, 1'b1, 16'd3, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 2'b00, 1'b0, 2'd0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd3, 1'b1};

    ARESETn = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge ACLK);
    chk("rst_tready", TREADY, 1'b0);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_odata", out_data, 16'h0);
    chk("rst_bytes", pkt_bytes, 16'h0);
    ARESETn = 1'b1;
    #1 chk("rst_tready_after_release", TREADY, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge ACLK);
      chk($sformatf("tbl%0d_tready", i), TREADY, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ovalid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_odata", i), out_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_olast", i), out_last, tbl[i].e_last);
      end
      chk($sformatf("tbl%0d_done", i), pkt_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_bytes", i), pkt_bytes, tbl[i].e_bytes);
      chk($sformatf("tbl%0d_iderr", i), id_err, tbl[i].e_err);
      drive(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].id, tbl[i].ord);
    end

    // Backpressure: fill 4 deep, 5th beat held off until a pop.
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk($sformatf("bp_rdy%0d", i), TREADY, 1'b1);
      drive(1'b1, 16'hB000 + 16'(i), 2'b11, 1'b0, 2'd0, 1'b0);
    end
    @(negedge ACLK);
    chk("bp_full_tready", TREADY, 1'b0);
    chk("bp_full_ovalid", out_valid, 1'b1);
    chk("bp_head0", out_data, 16'hB000);
    drive(1'b1, 16'hB004, 2'b11, 1'b1, 2'd0, 1'b0);
    @(negedge ACLK);
    chk("bp_still_full", TREADY, 1'b0);
    chk("bp_head0_held", out_data, 16'hB000);
    chk("bp_no_done", pkt_done, 1'b0);
    out_ready = 1'b1;
    @(negedge ACLK);
    chk("bp_rdy_after_pop", TREADY, 1'b1);
    chk("bp_head1", out_data, 16'hB001);
    @(negedge ACLK);
    chk("bp_head2", out_data, 16'hB002);
    chk("bp_done", pkt_done, 1'b1);
    chk("bp_bytes", pkt_bytes, 16'd10);
    chk("bp_iderr_sticky", id_err, 1'b1);
    TVALID = 1'b0;
    @(negedge ACLK);
    chk("bp_head3", out_data, 16'hB003);
    chk("bp_done_pulse", pkt_done, 1'b0);
    @(negedge ACLK);
    chk("bp_head4", out_data, 16'hB004);
    chk("bp_head4_last", out_last, 1'b1);
    @(negedge ACLK);
    chk("bp_drained", out_valid, 1'b0);

    // Reset in the middle of an open packet with beats buffered.
    drive(1'b1, 16'hD001, 2'b11, 1'b0, 2'd1, 1'b0);
    @(negedge ACLK);
    drive(1'b1, 16'hD002, 2'b11, 1'b0, 2'd1, 1'b0);
    @(negedge ACLK);
    TVALID = 1'b0;
    chk("mr_buffered", out_valid, 1'b1);
    ARESETn = 1'b0;
    #1;
    chk("mr_tready", TREADY, 1'b0);
    chk("mr_ovalid", out_valid, 1'b0);
    chk("mr_odata", out_data, 16'h0);
    chk("mr_olast", out_last, 1'b0);
    chk("mr_iderr", id_err, 1'b0);
    chk("mr_bytes", pkt_bytes, 16'h0);
    chk("mr_done", pkt_done, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1 chk("mr_tready_release", TREADY, 1'b0);
    @(negedge ACLK);
    chk("mr_tready_up", TREADY, 1'b1);
    chk("mr_empty", out_valid, 1'b0);
    drive(1'b1, 16'hE001, 2'b01, 1'b1, 2'd0, 1'b1);
    @(negedge ACLK);
    chk("mr_pkt_data", out_data, 16'hE001);
    chk("mr_pkt_done", pkt_done, 1'b1);
    chk("mr_pkt_bytes", pkt_bytes, 16'd1);
    chk("mr_pkt_iderr", id_err, 1'b0);
    TVALID = 1'b0;
    @(negedge ACLK);
    chk("mr_pkt_done_pulse", pkt_done, 1'b0);
    chk("mr_pkt_popped", out_valid, 1'b0);

    // 20 back-to-back beats with downstream always ready.
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      chk($sformatf("st%0d_tready", i), TREADY, 1'b1);
      if (i > 0) begin
        chk($sformatf("st%0d_ovalid", i), out_valid, 1'b1);
        chk($sformatf("st%0d_odata", i), out_data, 16'hC000 + 16'(i - 1));
      end
      drive(1'b1, 16'hC000 + 16'(i), 2'b11, (i == 19), 2'd2, 1'b1);
    end
    @(negedge ACLK);
    TVALID = 1'b0;
    chk("st_last_data", out_data, 16'hC013);
    chk("st_last_flag", out_last, 1'b1);
    chk("st_done", pkt_done, 1'b1);
    chk("st_bytes", pkt_bytes, 16'd40);
    chk("st_iderr", id_err, 1'b0);
`ifdef AXIS_RX_STATS_EN
    chk("st_beat_count", beat_count, 32'd21);
    chk("st_pkt_count", pkt_count, 32'd2);
`endif

    // Byte accumulator saturation: 32770 beats x 2 bytes.
    for (int i = 0; i < 32770; i++) begin
      @(negedge ACLK);
      drive(1'b1, 16'(i), 2'b11, (i == 32769), 2'd0, 1'b1);
    end
    @(negedge ACLK);
    TVALID = 1'b0;
    chk("sat_done", pkt_done, 1'b1);
    chk("sat_bytes", pkt_bytes, 16'hFFFF);
    @(negedge ACLK);
    chk("sat_done_pulse", pkt_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
